branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 SHALL have parameter BHT_IDX, default 4, meaning log2 of branch-history-table entries.
REQ-003 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 if_pc  in  XLEN  fetch PC for prediction lookup.
REQ-008 if_pred_taken  out  1  combinational prediction for if_pc.
REQ-009 ex_valid  in  1  resolve request this cycle.
REQ-010 ex_branch  in  3  000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu; 011 reserved.
REQ-011 ex_less, ex_zero  in  1 each  ALU compare flags.
REQ-012 ex_pc, ex_imm, ex_rs1  in  XLEN each  instruction PC, immediate, rs1 value.
REQ-013 ex_pred_taken  in  1  prediction carried from fetch.
REQ-014 res_valid  out  1  registered result strobe.
REQ-015 res_taken, res_mispredict  out  1 each  resolved direction; redirect required.
REQ-016 res_next_pc  out  XLEN  architecturally correct next PC.
REQ-017 res_pc_asrc, res_pc_bsrc  out  1 each  PC-adder selects (asrc: 0 = 4, 1 = imm; bsrc: 0 = PC, 1 = rs1).
REQ-018 stat_clr  in  1  synchronous clear of statistics.
REQ-019 stat_branches, stat_mispredicts  out  CNT_W each  event counters.

Function
REQ-020 Taken rule SHALL be: none 0; jal 1; jalr 1; beq zero; bne !zero; blt less; bge !less; 011 SHALL be treated as none.
REQ-021 asrc/bsrc SHALL be 00 for not taken, 10 for taken jal or conditional, and 11 for jalr.
REQ-022 Target SHALL be ex_pc+ex_imm, or (ex_rs1+ex_imm) with bit0 cleared for jalr; res_next_pc SHALL be target when taken, otherwise ex_pc+4, with all additions modulo 2^XLEN.
REQ-023 Mispredict SHALL be: conditional and none when taken != ex_pred_taken; jal when ex_pred_taken=0; jalr always 1 (no target predictor).
REQ-024 Latency SHALL be one cycle: results for an ex_valid cycle SHALL appear registered on the next cycle with res_valid=1; otherwise res_valid=0, with other res_* outputs held.
REQ-025 The BHT SHALL hold 2^BHT_IDX 2-bit saturating counters indexed by pc[BHT_IDX+1:2], and if_pred_taken SHALL be the MSB of entry(if_pc).
REQ-026 On ex_valid with a conditional branch, entry(ex_pc) SHALL increment if taken and decrement if not, saturating at 11 and 00; jal, jalr and none SHALL NOT update.
REQ-027 The BHT write SHALL occur at the clock edge, so a same-cycle lookup of the same index returns the old value (no bypass).
REQ-028 stat_branches SHALL +1 per ex_valid with type != none, and stat_mispredicts SHALL +1 per mispredicting ex_valid; both SHALL saturate at all-ones.
REQ-029 stat_clr SHALL zero both counters and take priority over a same-cycle increment.

Reset
REQ-030 On rst_n low, all BHT entries SHALL become 01 (weakly not taken), res_* and stat_* SHALL become 0, and if_pred_taken SHALL read 0.
REQ-031 Reset mid-operation SHALL discard any pending result; the first res_valid SHALL follow the first ex_valid after release.

Structure
REQ-032 A shared package SHALL hold the branch-type encodings (BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE) and the BHT reset constant 2'b01.
REQ-033 The counter table SHALL be one sub-module, branch_bht (one async read port, one sync update port).

Verification
REQ-034 Reset, then if_pc=0x80000000 -> if_pred_taken=0, stat_*=0, res_valid=0.
REQ-035 beq at pc 0x80000010, zero=1, pred=0, imm=0x20 -> next cycle res_taken=1, mispredict=1, next_pc=0x80000030, asrc/bsrc=10.
REQ-036 Two taken beq at the same pc -> if_pred_taken for that pc becomes 1 after the first; after four total, the entry reads 11 and a fifth taken leaves it at 11.
REQ-037 jalr with rs1=0x80001003, imm=4, pred=1 -> next_pc=0x80001006, mispredict=1, asrc/bsrc=11.
REQ-038 Branch 011 with pred=1 -> taken=0, mispredict=1, next_pc=pc+4, BHT unchanged.
REQ-039 CNT_W=4 with 16 branches, then stat_clr together with one more branch -> counter holds 15, then reads 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-type encodings and BHT helpers for the
// branch resolve unit and its prediction table.
package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_RSVD = 3'b011,
        BR_BEQ  = 3'b100,
        BR_BNE  = 3'b101,
        BR_BLT  = 3'b110,
        BR_BGE  = 3'b111
    } br_type_e;

    localparam logic [1:0] BHT_RST = 2'b01;

    function automatic logic [1:0] sat2(
        input logic [1:0] c,
        input logic       up
    );
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Table of 2-bit saturating direction counters.
// Async read for fetch lookup, write at the clock edge.
module branch_bht
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output logic [1:0]     rd_cnt,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic           wr_taken
);

    localparam int N = 1 << IDX;

    logic [1:0] tbl [N];

    assign rd_cnt = tbl[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                tbl[i] <= BHT_RST;
        end else if (wr_en) begin
            tbl[wr_idx] <= sat2(tbl[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch direction/target one cycle after EX,
// trains the BHT and keeps branch/mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int BHT_IDX = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_branch,
    input  logic             ex_less,
    input  logic             ex_zero,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_next_pc,
    output logic             res_pc_asrc,
    output logic             res_pc_bsrc,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    logic            taken;
    logic            mispred;
    logic            is_br;
    logic            is_cond;
    logic            is_jalr;
    logic            asrc;
    logic            bsrc;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] next_pc;
    logic [1:0]      rd_cnt;

    always_comb begin
        taken   = 1'b0;
        mispred = ex_pred_taken;
        is_br   = 1'b1;
        is_cond = 1'b1;
        is_jalr = 1'b0;
        case (ex_branch)
            BR_JAL: begin
                taken   = 1'b1;
                mispred = !ex_pred_taken;
                is_cond = 1'b0;
            end
            BR_JALR: begin
                taken   = 1'b1;
                mispred = 1'b1;
                is_cond = 1'b0;
                is_jalr = 1'b1;
            end
            BR_BEQ:  taken = ex_zero;
            BR_BNE:  taken = !ex_zero;
            BR_BLT:  taken = ex_less;
            BR_BGE:  taken = !ex_less;
            default: begin
                is_br   = 1'b0;
                is_cond = 1'b0;
            end
        endcase
        if (is_cond)
            mispred = taken ^ ex_pred_taken;
    end

    // One PC adder covers pc+4, pc+imm and rs1+imm.
    assign asrc    = taken;
    assign bsrc    = is_jalr;
    assign op_a    = asrc ? ex_imm : XLEN'(4);
    assign op_b    = bsrc ? ex_rs1 : ex_pc;
    assign sum     = op_a + op_b;
    assign next_pc = {sum[XLEN-1:1], sum[0] & !is_jalr};

    branch_bht #(.IDX(BHT_IDX)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[BHT_IDX+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (ex_valid && is_cond),
        .wr_idx   (ex_pc[BHT_IDX+1:2]),
        .wr_taken (taken)
    );

    assign if_pred_taken = rd_cnt[1];

    logic unused_bits;
    assign unused_bits = ^{if_pc[XLEN-1:BHT_IDX+2], if_pc[1:0], rd_cnt[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            res_next_pc    <= '0;
            res_pc_asrc    <= 1'b0;
            res_pc_bsrc    <= 1'b0;
        end else begin
            res_valid <= ex_valid;
            if (ex_valid) begin
                res_taken      <= taken;
                res_mispredict <= mispred;
                res_next_pc    <= next_pc;
                res_pc_asrc    <= asrc;
                res_pc_bsrc    <= bsrc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (stat_clr) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (ex_valid) begin
            if (is_br && !(&stat_branches))
                stat_branches <= stat_branches + CNT_W'(1);
            if (mispred && !(&stat_mispredicts))
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
        end
    end

endmodule
